// File: rtl/me_dmem_port.sv
// me_dmem_port: memory-stage data-memory access unit.
// Takes the ME-stage address, store data and load/store type, runs one
// valid/ready request (plus a response wait for loads) on the data-memory
// bus, returns aligned and extended load data, and stalls the upstream
// EX->ME register while an access is in flight.
//
// Optional feature macro: MISALIGN_TRAP_EN. When defined, misaligned
// halfword/word accesses skip the bus and pulse me_misaligned. When left
// undefined, me_misaligned stays 0 and offending low address bits are ignored.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   me_alu_result                effective byte address
//   me_data_rs2_data             store data
//   me_control_mem_read  [2:0]   load type (LB/LH/LW/LBU/LHU, else none)
//   me_control_mem_write [1:0]   store type (SB/SH/SW, 00 none)
//   dmem_req_*, dmem_addr/we/wstrb/wdata   registered request bus
//   dmem_rsp_valid, dmem_rdata   load response channel
//   me_load_data                 extended load result, held until next load
//   me_stall                     hold upstream pipeline register
//   me_bus_err                   one-cycle pulse on access timeout
//   me_misaligned                one-cycle pulse on trapped misaligned access
//
// State | meaning
// IDLE  | waiting for an access; latches the request when one appears
// REQ   | request valid on the bus, waiting for ready
// RESP  | load accepted, waiting for the response word
// DONE  | one-cycle completion; stall released so upstream advances
module me_dmem_port #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] me_alu_result,
  input  logic [DATA_WIDTH-1:0] me_data_rs2_data,
  input  logic [2:0]            me_control_mem_read,
  input  logic [1:0]            me_control_mem_write,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic                  dmem_we,
  output logic [3:0]            dmem_wstrb,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic [DATA_WIDTH-1:0] me_load_data,
  output logic                  me_stall,
  output logic                  me_bus_err,
  output logic                  me_misaligned
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

  localparam logic [9:0] CNT_LAST = 10'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  ld_type_q, ld_type_d;
  logic        is_load_q, is_load_d;
  logic [1:0]  off_q, off_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [31:0] load_data_q, load_data_d;
  logic        bus_err_q, bus_err_d;
  logic        misaligned_q, misaligned_d;

  logic        is_load, is_store, access, mis_access;
  logic [1:0]  sz, eff_off;
  logic [3:0]  wstrb_new;
  logic [31:0] wdata_new, rd_shift, ld_ext;

  always_comb begin
    is_load = 1'b0;
    case (me_control_mem_read)
      3'b001, 3'b010, 3'b011, 3'b101, 3'b110: is_load = 1'b1;
      default:                                 is_load = 1'b0;
    endcase
  end

  assign is_store = (me_control_mem_write != 2'b00);
  assign access   = is_load | is_store;
  // Load and store encodings share the low two bits for size: 01 byte, 10 half, 11 word.
  assign sz       = is_load ? me_control_mem_read[1:0] : me_control_mem_write;

  always_comb begin
    eff_off = 2'b00;
    case (sz)
      2'b01:   eff_off = me_alu_result[1:0];
      2'b10:   eff_off = {me_alu_result[1], 1'b0};
      default: eff_off = 2'b00;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign mis_access = ((sz == 2'b10) && me_alu_result[0]) ||
                      ((sz == 2'b11) && (me_alu_result[1:0] != 2'b00));
`else
  assign mis_access = 1'b0;
`endif

  always_comb begin
    wstrb_new = 4'b0000;
    wdata_new = 32'h0;
    if (!is_load) begin
      case (sz)
        2'b01: begin
          wstrb_new = 4'b0001 << eff_off;
          wdata_new = {4{me_data_rs2_data[7:0]}};
        end
        2'b10: begin
          wstrb_new = me_alu_result[1] ? 4'b1100 : 4'b0011;
          wdata_new = {2{me_data_rs2_data[15:0]}};
        end
        2'b11: begin
          wstrb_new = 4'b1111;
          wdata_new = me_data_rs2_data;
        end
        default: begin
          wstrb_new = 4'b0000;
          wdata_new = 32'h0;
        end
      endcase
    end
  end

  assign rd_shift = dmem_rdata >> {off_q, 3'b000};

  always_comb begin
    ld_ext = rd_shift;
    case (ld_type_q)
      3'b001:  ld_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b010:  ld_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b101:  ld_ext = {24'h0, rd_shift[7:0]};
      3'b110:  ld_ext = {16'h0, rd_shift[15:0]};
      default: ld_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    req_valid_d  = req_valid_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    ld_type_d    = ld_type_q;
    is_load_d    = is_load_q;
    off_d        = off_q;
    cnt_d        = cnt_q;
    load_data_d  = load_data_q;
    bus_err_d    = 1'b0;
    misaligned_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          is_load_d = is_load;
          ld_type_d = me_control_mem_read;
          off_d     = eff_off;
          cnt_d     = 10'd0;
          if (mis_access) begin
            state_d      = S_DONE;
            misaligned_d = 1'b1;
            if (is_load) load_data_d = 32'h0;
          end else begin
            state_d     = S_REQ;
            req_valid_d = 1'b1;
            addr_d      = {me_alu_result[31:2], 2'b00};
            we_d        = ~is_load;
            wstrb_d     = wstrb_new;
            wdata_d     = wdata_new;
          end
        end
      end
      S_REQ: begin
        if (dmem_req_ready) begin
          req_valid_d = 1'b0;
          cnt_d       = 10'd0;
          state_d     = is_load_q ? S_RESP : S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          req_valid_d = 1'b0;
          state_d     = S_DONE;
          bus_err_d   = 1'b1;
          if (is_load_q) load_data_d = 32'h0;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      S_RESP: begin
        if (dmem_rsp_valid) begin
          load_data_d = ld_ext;
          state_d     = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          load_data_d = 32'h0;
          state_d     = S_DONE;
          bus_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      default: begin
        // DONE always retires; the upstream register advances on this edge.
        state_d = S_IDLE;
        cnt_d   = 10'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_valid_q  <= 1'b0;
      addr_q       <= 32'h0;
      we_q         <= 1'b0;
      wstrb_q      <= 4'b0000;
      wdata_q      <= 32'h0;
      ld_type_q    <= 3'b000;
      is_load_q    <= 1'b0;
      off_q        <= 2'b00;
      cnt_q        <= 10'd0;
      load_data_q  <= 32'h0;
      bus_err_q    <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_valid_q  <= req_valid_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
      ld_type_q    <= ld_type_d;
      is_load_q    <= is_load_d;
      off_q        <= off_d;
      cnt_q        <= cnt_d;
      load_data_q  <= load_data_d;
      bus_err_q    <= bus_err_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign dmem_req_valid = req_valid_q;
  assign dmem_addr      = addr_q;
  assign dmem_we        = we_q;
  assign dmem_wstrb     = wstrb_q;
  assign dmem_wdata     = wdata_q;
  assign me_load_data   = load_data_q;
  assign me_bus_err     = bus_err_q;
  assign me_misaligned  = misaligned_q;
  assign me_stall       = ((state_q == S_IDLE) && access) ||
                          (state_q == S_REQ) || (state_q == S_RESP);

endmodule

// File: tb/tb_me_dmem_port.sv
module tb_me_dmem_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] me_alu_result, me_data_rs2_data;
  logic [2:0]  me_control_mem_read;
  logic [1:0]  me_control_mem_write;
  logic        dmem_req_valid, dmem_req_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, me_load_data;
  logic        dmem_we, dmem_rsp_valid;
  logic [3:0]  dmem_wstrb;
  logic        me_stall, me_bus_err, me_misaligned;

  int n_tests = 0;
  int n_fail  = 0;

  // Observations of the most recent access.
  int          obs_stall, obs_req, obs_err, obs_mis;
  logic        obs_stable, obs_hung, obs_post_stall, obs_post_valid;
  logic [31:0] obs_addr, obs_wdata, obs_load;
  logic [3:0]  obs_wstrb;
  logic        obs_we;

  me_dmem_port #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .me_alu_result(me_alu_result), .me_data_rs2_data(me_data_rs2_data),
    .me_control_mem_read(me_control_mem_read), .me_control_mem_write(me_control_mem_write),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
    .me_load_data(me_load_data), .me_stall(me_stall),
    .me_bus_err(me_bus_err), .me_misaligned(me_misaligned)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    me_control_mem_read  = 3'b000;
    me_control_mem_write = 2'b00;
    me_alu_result        = 32'h0;
    me_data_rs2_data     = 32'h0;
    dmem_req_ready       = 1'b0;
    dmem_rsp_valid       = 1'b0;
  endtask

  // Drives one access through the stage acting as a simple memory; records
  // what was seen on the bus. rsp_dly < 0 means the response never comes.
  task automatic run_access(input logic [2:0] ld, input logic [1:0] st,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] rd, input int rdy_dly, input int rsp_dly);
    int rdy_cnt, rsp_cnt;
    bit in_resp, fin;
    obs_stall = 0; obs_req = 0; obs_err = 0; obs_mis = 0;
    obs_stable = 1'b1; obs_hung = 1'b1; obs_load = 32'hX;
    obs_addr = 32'hX; obs_wdata = 32'hX; obs_wstrb = 4'hX; obs_we = 1'bX;
    rdy_cnt = 0; rsp_cnt = 0; in_resp = 0; fin = 0;
    @(negedge clk);
    me_control_mem_read  = ld;
    me_control_mem_write = st;
    me_alu_result        = a;
    me_data_rs2_data     = d;
    dmem_rdata           = rd;
    dmem_req_ready       = 1'b0;
    dmem_rsp_valid       = 1'b0;
    for (int c = 0; c < 200 && !fin; c++) begin
      #1;
      if (me_bus_err) obs_err++;
      if (me_misaligned) obs_mis++;
      if (c > 0 && !me_stall) begin
        obs_load = me_load_data;
        obs_hung = 1'b0;
        fin = 1;
        clear_inputs();
      end else begin
        if (me_stall) obs_stall++;
        dmem_rsp_valid = 1'b0;
        if (in_resp && rsp_dly >= 0) begin
          if (rsp_cnt >= rsp_dly) dmem_rsp_valid = 1'b1;
          else rsp_cnt++;
        end
        dmem_req_ready = 1'b0;
        if (dmem_req_valid) begin
          if (obs_req == 0) begin
            obs_addr = dmem_addr; obs_wdata = dmem_wdata;
            obs_wstrb = dmem_wstrb; obs_we = dmem_we;
          end else if (obs_addr !== dmem_addr || obs_wdata !== dmem_wdata ||
                       obs_wstrb !== dmem_wstrb || obs_we !== dmem_we) begin
            obs_stable = 1'b0;
          end
          obs_req++;
          if (rdy_cnt >= rdy_dly) begin
            dmem_req_ready = 1'b1;
            if (ld != 3'b000) in_resp = 1;
          end else begin
            rdy_cnt++;
          end
        end
        @(negedge clk);
      end
    end
    if (!fin) clear_inputs();
    @(negedge clk);
    #1;
    obs_post_stall = me_stall;
    obs_post_valid = dmem_req_valid;
    if (me_bus_err) obs_err++;
    if (me_misaligned) obs_mis++;
  endtask

  task automatic test_reset();
    clear_inputs();
    dmem_rdata = 32'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if ({dmem_req_valid, dmem_we, dmem_wstrb, me_bus_err, me_misaligned, me_stall} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got v=%b we=%b wstrb=%b err=%b mis=%b stall=%b required all 0",
               dmem_req_valid, dmem_we, dmem_wstrb, me_bus_err, me_misaligned, me_stall);
    end
    n_tests++;
    if ({dmem_addr, dmem_wdata, me_load_data} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%h wdata=%h load=%h required 0", dmem_addr, dmem_wdata, me_load_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_sw();
    run_access(3'b000, 2'b11, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0);
    n_tests++;
    if (obs_req !== 1 || obs_addr !== 32'h100 || obs_we !== 1'b1 || obs_wstrb !== 4'b1111 || obs_wdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL sw_bus: got req=%0d addr=%h we=%b wstrb=%b wdata=%h required 1 100 1 1111 deadbeef",
               obs_req, obs_addr, obs_we, obs_wstrb, obs_wdata);
    end
    n_tests++;
    if (obs_stall !== 2 || obs_hung !== 1'b0 || obs_post_stall !== 1'b0 || obs_err !== 0) begin
      n_fail++;
      $display("FAIL sw_stall: got stall_cycles=%0d hung=%b post=%b err=%0d required 2 0 0 0",
               obs_stall, obs_hung, obs_post_stall, obs_err);
    end
  endtask

  task automatic test_sb_sh();
    run_access(3'b000, 2'b01, 32'h203, 32'h000000A5, 32'h0, 0, 0);
    n_tests++;
    if (obs_addr !== 32'h200 || obs_wstrb !== 4'b1000 || obs_wdata !== 32'hA5A5A5A5 || obs_we !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_bus: got addr=%h wstrb=%b wdata=%h we=%b required 200 1000 a5a5a5a5 1",
               obs_addr, obs_wstrb, obs_wdata, obs_we);
    end
    run_access(3'b000, 2'b10, 32'h102, 32'h1234ABCD, 32'h0, 0, 0);
    n_tests++;
    if (obs_addr !== 32'h100 || obs_wstrb !== 4'b1100 || obs_wdata !== 32'hABCDABCD) begin
      n_fail++;
      $display("FAIL sh_bus: got addr=%h wstrb=%b wdata=%h required 100 1100 abcdabcd",
               obs_addr, obs_wstrb, obs_wdata);
    end
  endtask

  task automatic test_lb_lbu();
    run_access(3'b001, 2'b00, 32'h202, 32'h0, 32'h00800000, 0, 0);
    n_tests++;
    if (obs_load !== 32'hFFFFFF80 || obs_addr !== 32'h200 || obs_we !== 1'b0 || obs_wstrb !== 4'b0000) begin
      n_fail++;
      $display("FAIL lb: got load=%h addr=%h we=%b wstrb=%b required ffffff80 200 0 0000",
               obs_load, obs_addr, obs_we, obs_wstrb);
    end
    n_tests++;
    if (obs_stall !== 3) begin
      n_fail++;
      $display("FAIL lb_latency: got stall_cycles=%0d required 3", obs_stall);
    end
    run_access(3'b101, 2'b00, 32'h202, 32'h0, 32'h00800000, 0, 0);
    n_tests++;
    if (obs_load !== 32'h00000080) begin
      n_fail++;
      $display("FAIL lbu: got load=%h required 00000080", obs_load);
    end
    // A store in between must not disturb the held load result.
    run_access(3'b000, 2'b11, 32'h10, 32'h55555555, 32'h0, 0, 0);
    n_tests++;
    if (me_load_data !== 32'h00000080) begin
      n_fail++;
      $display("FAIL load_hold: got load=%h required 00000080", me_load_data);
    end
  endtask

  task automatic test_lh_delayed();
    run_access(3'b010, 2'b00, 32'h102, 32'h0, 32'h80011234, 3, 0);
    n_tests++;
    if (obs_req !== 4 || obs_stable !== 1'b1 || obs_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL lh_wait: got req_cycles=%0d stable=%b addr=%h required 4 1 100",
               obs_req, obs_stable, obs_addr);
    end
    n_tests++;
    if (obs_load !== 32'hFFFF8001 || obs_stall !== 6) begin
      n_fail++;
      $display("FAIL lh_data: got load=%h stall_cycles=%0d required ffff8001 6", obs_load, obs_stall);
    end
  endtask

  task automatic test_load_priority();
    run_access(3'b011, 2'b11, 32'h300, 32'hFFFFFFFF, 32'hCAFEF00D, 0, 0);
    n_tests++;
    if (obs_we !== 1'b0 || obs_wstrb !== 4'b0000 || obs_load !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL ld_priority: got we=%b wstrb=%b load=%h required 0 0000 cafef00d",
               obs_we, obs_wstrb, obs_load);
    end
  endtask

  task automatic test_timeout();
    run_access(3'b011, 2'b00, 32'h400, 32'h0, 32'h12345678, 0, -1);
    n_tests++;
    if (obs_err !== 1 || obs_load !== 32'h0 || obs_hung !== 1'b0 || obs_post_stall !== 1'b0 || obs_stall !== 6) begin
      n_fail++;
      $display("FAIL timeout_resp: got err=%0d load=%h hung=%b post=%b stall_cycles=%0d required 1 0 0 0 6",
               obs_err, obs_load, obs_hung, obs_post_stall, obs_stall);
    end
    run_access(3'b000, 2'b11, 32'h404, 32'h1, 32'h0, 1000, 0);
    n_tests++;
    if (obs_err !== 1 || obs_req !== 4 || obs_post_valid !== 1'b0 || obs_hung !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_req: got err=%0d req_cycles=%0d post_valid=%b hung=%b required 1 4 0 0",
               obs_err, obs_req, obs_post_valid, obs_hung);
    end
  endtask

  task automatic test_misaligned();
    run_access(3'b011, 2'b00, 32'h101, 32'h0, 32'h12345678, 0, 0);
`ifdef MISALIGN_TRAP_EN
    n_tests++;
    if (obs_req !== 0 || obs_mis !== 1 || obs_load !== 32'h0 || obs_hung !== 1'b0) begin
      n_fail++;
      $display("FAIL misaligned_trap: got req=%0d mis=%0d load=%h hung=%b required 0 1 0 0",
               obs_req, obs_mis, obs_load, obs_hung);
    end
`else
    n_tests++;
    if (obs_req !== 1 || obs_addr !== 32'h100 || obs_mis !== 0 || obs_load !== 32'h12345678) begin
      n_fail++;
      $display("FAIL misaligned_ignore: got req=%0d addr=%h mis=%0d load=%h required 1 100 0 12345678",
               obs_req, obs_addr, obs_mis, obs_load);
    end
`endif
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    me_control_mem_read = 3'b011;
    me_alu_result       = 32'h40;
    dmem_rdata          = 32'hBADDF00D;
    @(negedge clk);
    #1;
    n_tests++;
    if (dmem_req_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_setup: got valid=%b required 1", dmem_req_valid);
    end
    rst = 1'b1;
    clear_inputs();
    dmem_rsp_valid = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    n_tests++;
    if (dmem_req_valid !== 1'b0 || me_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_idle: got valid=%b stall=%b required 0 0", dmem_req_valid, me_stall);
    end
    @(negedge clk);
    #1;
    dmem_rsp_valid = 1'b0;
    n_tests++;
    if (me_load_data !== 32'h0 || me_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_rsp: got load=%h stall=%b required 0 0", me_load_data, me_stall);
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_sw();
    test_sb_sh();
    test_lb_lbu();
    test_lh_delayed();
    test_load_priority();
    test_timeout();
    test_misaligned();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
